// File: rtl/add_round_key_stage.sv
// AES AddRoundKey pipeline stage with an on-the-fly key schedule.
// Walks the round keys forward (OP=1) or backward (OP=0), XORing one state beat per round.
module add_round_key_stage #(
  parameter int unsigned OP = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load_i,
  input  logic [127:0] key_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [127:0] s_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [127:0] s_o,
  output logic [3:0]   round_o,
  output logic         last_o
);

  localparam logic [7:0] RCON_INIT = (OP != 0) ? 8'h01 : 8'h36;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  logic [127:0] rk_q, rk_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   cnt_q;
  logic         loaded_q;
  logic         m_valid_q;
  logic [127:0] s_q;
  logic [3:0]   round_q;
  logic         last_q;
  logic         accept;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] n0, n1, n2, n3;
  logic [31:0] sub_in, sub_out;

  assign s_ready_o = loaded_q && (cnt_q < 4'd11) && !key_load_i && (!m_valid_q || m_ready_i);
  assign accept    = s_valid_i && s_ready_o;

  assign m_valid_o = m_valid_q;
  assign s_o       = s_q;
  assign round_o   = round_q;
  assign last_o    = last_q;

  // One round of key schedule; the backward walk recovers w3 first so it can feed SubWord.
  always_comb begin
    {w0, w1, w2, w3} = rk_q;
    sub_in  = (OP != 0) ? w3 : (w3 ^ w2);
    sub_out = {sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0]), sbox(sub_in[31:24])};
    n0 = '0;
    n1 = '0;
    n2 = '0;
    n3 = '0;
    rcon_d = rcon_q;
    if (OP != 0) begin
      n0 = w0 ^ sub_out ^ {rcon_q, 24'h0};
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
      rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end else begin
      n3 = w3 ^ w2;
      n2 = w2 ^ w1;
      n1 = w1 ^ w0;
      n0 = w0 ^ sub_out ^ {rcon_q, 24'h0};
      rcon_d = rcon_q[0] ? (((rcon_q ^ 8'h1b) >> 1) | 8'h80) : (rcon_q >> 1);
    end
    rk_d = {n0, n1, n2, n3};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_q      <= '0;
      rcon_q    <= RCON_INIT;
      cnt_q     <= '0;
      loaded_q  <= 1'b0;
      m_valid_q <= 1'b0;
      s_q       <= '0;
      round_q   <= '0;
      last_q    <= 1'b0;
    end else if (key_load_i) begin
      rk_q      <= key_i;
      rcon_q    <= RCON_INIT;
      cnt_q     <= '0;
      loaded_q  <= 1'b1;
      m_valid_q <= 1'b0;
    end else if (accept) begin
      s_q       <= s_i ^ rk_q;
      m_valid_q <= 1'b1;
      round_q   <= (OP != 0) ? cnt_q : (4'd10 - cnt_q);
      last_q    <= (cnt_q == 4'd10);
      cnt_q     <= cnt_q + 4'd1;
      rk_q      <= rk_d;
      rcon_q    <= rcon_d;
    end else if (m_ready_i) begin
      m_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_round_key_stage.sv
// Runs an encrypt-order and a decrypt-order stage in lockstep on shared stimulus and
// compares both against a full AES-128 key expansion built from GF(2^8) arithmetic.
module tb_add_round_key_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         keyLoad, sValid, mReady;
  logic [127:0] encKey, decKey, sIn;
  logic         encSReady, encMValid, encLast;
  logic         decSReady, decMValid, decLast;
  logic [127:0] encSOut, decSOut;
  logic [3:0]   encRound, decRound;

  add_round_key_stage #(.OP(1)) dutEnc (
    .clk(clk), .rst_n(rst_n), .key_load_i(keyLoad), .key_i(encKey),
    .s_valid_i(sValid), .s_ready_o(encSReady), .s_i(sIn),
    .m_valid_o(encMValid), .m_ready_i(mReady), .s_o(encSOut),
    .round_o(encRound), .last_o(encLast)
  );

  add_round_key_stage #(.OP(0)) dutDec (
    .clk(clk), .rst_n(rst_n), .key_load_i(keyLoad), .key_i(decKey),
    .s_valid_i(sValid), .s_ready_o(decSReady), .s_i(sIn),
    .m_valid_o(decMValid), .m_ready_i(mReady), .s_o(decSOut),
    .round_o(decRound), .last_o(decLast)
  );

  logic [7:0]   sboxTab [256];
  logic [127:0] roundKeys [11];
  int           mCnt;
  bit           mLoaded, eValid, eLast;
  logic [127:0] eEncS, eDecS;
  int           eEncRound, eDecRound;
  int           testsRun = 0;
  int           testsFailed = 0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from first principles: multiplicative inverse followed by the affine map.
  task automatic buildSbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sboxTab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subRot(input logic [31:0] t);
    logic [31:0] r;
    r = {t[23:0], t[31:24]};
    return {sboxTab[r[31:24]], sboxTab[r[23:16]], sboxTab[r[15:8]], sboxTab[r[7:0]]};
  endfunction

  task automatic expandKey(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    {w[0], w[1], w[2], w[3]} = key;
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = subRot(t) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) roundKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic bit expReady();
    return mLoaded && (mCnt < 11) && !keyLoad && (!eValid || mReady);
  endfunction

  task automatic modelReset();
    mLoaded = 0; mCnt = 0; eValid = 0; eLast = 0;
    eEncS = '0; eDecS = '0; eEncRound = 0; eDecRound = 0;
  endtask

  // Advances the reference model for the inputs now driven, then clocks once (negedge to negedge).
  task automatic applyStimulus();
    if (keyLoad) begin
      mLoaded = 1; mCnt = 0; eValid = 0;
    end else if (sValid && expReady()) begin
      eEncS = sIn ^ roundKeys[mCnt];
      eDecS = sIn ^ roundKeys[10 - mCnt];
      eEncRound = mCnt;
      eDecRound = 10 - mCnt;
      eLast = (mCnt == 10);
      eValid = 1;
      mCnt++;
    end else if (mReady) begin
      eValid = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic startKey(input logic [127:0] cipher);
    expandKey(cipher);
    encKey = cipher;
    decKey = roundKeys[10];
    keyLoad = 1'b1;
    sValid = 1'b0;
    applyStimulus();
    keyLoad = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; keyLoad = 1'b0; sValid = 1'b1; mReady = 1'b1;
    sIn = {$urandom, $urandom, $urandom, $urandom};
    #1;
    testsRun++;
    if ({encMValid, encSReady, encSOut, encRound, encLast} !== '0 ||
        {decMValid, decSReady, decSOut, decRound, decLast} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_state: enc v=%0b r=%0b s=%h rnd=%0d l=%0b dec v=%0b r=%0b s=%h rnd=%0d l=%0b, required all 0",
               encMValid, encSReady, encSOut, encRound, encLast, decMValid, decSReady, decSOut, decRound, decLast);
    end
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    for (int c = 0; c < 4; c++) begin
      sIn = {$urandom, $urandom, $urandom, $urandom};
      #1;
      testsRun++;
      if (encSReady !== 1'b0 || decSReady !== 1'b0 || encMValid !== 1'b0 || decMValid !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL no_accept_before_key: ready=%0b/%0b valid=%0b/%0b, required 0",
                 encSReady, decSReady, encMValid, decMValid);
      end
      applyStimulus();
    end
  endtask

  task automatic test_known_vectors();
    startKey(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
    for (int b = 0; b < 11; b++) begin
      sValid = 1'b1; sIn = '0; mReady = 1'b1;
      #1;
      testsRun++;
      if (encSReady !== 1'b1 || decSReady !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL vec_ready beat %0d: ready=%0b/%0b, required 1", b, encSReady, decSReady);
      end
      applyStimulus();
      testsRun++;
      if (encMValid !== 1'b1 || encSOut !== eEncS || encRound !== 4'(b) || encLast !== (b == 10) ||
          decMValid !== 1'b1 || decSOut !== eDecS || decRound !== 4'(10 - b) || decLast !== (b == 10)) begin
        testsFailed++;
        $display("[TB] FAIL vec_beat %0d: enc %h r%0d l%0b dec %h r%0d l%0b, required enc %h r%0d dec %h r%0d last %0b",
                 b, encSOut, encRound, encLast, decSOut, decRound, decLast, eEncS, b, eDecS, 10 - b, b == 10);
      end
      if (b == 0 || b == 1 || b == 10) begin
        testsRun++;
        if ((b == 0  && encSOut !== 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c) ||
            (b == 1  && encSOut !== 128'ha0fafe17_88542cb1_23a33939_2a6c7605) ||
            (b == 10 && (encSOut !== 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6 ||
                         decSOut !== 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c ||
                         decRound !== 4'd0 || encLast !== 1'b1 || decLast !== 1'b1))) begin
          testsFailed++;
          $display("[TB] FAIL vec_fips197 beat %0d: enc=%h dec=%h dec_round=%0d", b, encSOut, decSOut, decRound);
        end
      end
    end
    #1;
    testsRun++;
    if (encSReady !== 1'b0 || decSReady !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL vec_done_ready: ready=%0b/%0b, required 0", encSReady, decSReady);
    end
    applyStimulus();
    testsRun++;
    if (encMValid !== 1'b0 || decMValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL vec_done_valid: valid=%0b/%0b, required 0", encMValid, decMValid);
    end
  endtask

  task automatic test_backpressure();
    startKey({$urandom, $urandom, $urandom, $urandom});
    sValid = 1'b1; mReady = 1'b1; sIn = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus();
    for (int c = 0; c < 3; c++) begin
      mReady = 1'b0; sIn = {$urandom, $urandom, $urandom, $urandom};
      #1;
      testsRun++;
      if (encSReady !== 1'b0 || decSReady !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL bp_ready cycle %0d: ready=%0b/%0b, required 0", c, encSReady, decSReady);
      end
      applyStimulus();
      testsRun++;
      if (encMValid !== 1'b1 || encSOut !== eEncS || encRound !== 4'd0 ||
          decMValid !== 1'b1 || decSOut !== eDecS || decRound !== 4'd10) begin
        testsFailed++;
        $display("[TB] FAIL bp_hold cycle %0d: enc %h r%0d dec %h r%0d, required enc %h r0 dec %h r10",
                 c, encSOut, encRound, decSOut, decRound, eEncS, eDecS);
      end
    end
    for (int b = 1; b < 11; b++) begin
      mReady = 1'b1; sIn = {$urandom, $urandom, $urandom, $urandom};
      #1;
      testsRun++;
      if (encSReady !== 1'b1 || decSReady !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL bp_stream_ready beat %0d: ready=%0b/%0b, required 1", b, encSReady, decSReady);
      end
      applyStimulus();
      testsRun++;
      if (encMValid !== 1'b1 || encSOut !== eEncS || encRound !== 4'(b) ||
          decMValid !== 1'b1 || decSOut !== eDecS || decRound !== 4'(10 - b)) begin
        testsFailed++;
        $display("[TB] FAIL bp_stream beat %0d: enc %h r%0d dec %h r%0d, required enc %h r%0d dec %h r%0d",
                 b, encSOut, encRound, decSOut, decRound, eEncS, b, eDecS, 10 - b);
      end
    end
    sValid = 1'b0;
    applyStimulus();
  endtask

  task automatic test_abort();
    logic [127:0] newKey, beat;
    startKey({$urandom, $urandom, $urandom, $urandom});
    sValid = 1'b1; mReady = 1'b1;
    for (int b = 0; b < 5; b++) begin
      sIn = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus();
    end
    newKey = {$urandom, $urandom, $urandom, $urandom};
    expandKey(newKey);
    encKey = newKey;
    decKey = roundKeys[10];
    keyLoad = 1'b1;
    sIn = {$urandom, $urandom, $urandom, $urandom};
    #1;
    testsRun++;
    if (encSReady !== 1'b0 || decSReady !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL abort_ready: ready=%0b/%0b, required 0", encSReady, decSReady);
    end
    applyStimulus();
    keyLoad = 1'b0;
    testsRun++;
    if (encMValid !== 1'b0 || decMValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL abort_drop: valid=%0b/%0b, required 0", encMValid, decMValid);
    end
    beat = {$urandom, $urandom, $urandom, $urandom};
    sIn = beat;
    applyStimulus();
    testsRun++;
    if (encMValid !== 1'b1 || encRound !== 4'd0 || encSOut !== (beat ^ newKey) ||
        decMValid !== 1'b1 || decRound !== 4'd10 || decSOut !== eDecS) begin
      testsFailed++;
      $display("[TB] FAIL abort_restart: enc %h r%0d dec %h r%0d, required enc %h r0 dec %h r10",
               encSOut, encRound, decSOut, decRound, beat ^ newKey, eDecS);
    end
    sValid = 1'b0;
    applyStimulus();
  endtask

  task automatic test_reset_midsequence();
    startKey({$urandom, $urandom, $urandom, $urandom});
    sValid = 1'b1; mReady = 1'b1;
    for (int b = 0; b < 4; b++) begin
      sIn = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus();
    end
    #1;
    rst_n = 1'b0;
    #1;
    modelReset();
    testsRun++;
    if ({encMValid, encSReady, encSOut, encRound, encLast} !== '0 ||
        {decMValid, decSReady, decSOut, decRound, decLast} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_outputs: enc v=%0b s=%h r%0d dec v=%0b s=%h r%0d, required all 0",
               encMValid, encSOut, encRound, decMValid, decSOut, decRound);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      testsRun++;
      if (encSReady !== 1'b0 || decSReady !== 1'b0 || encMValid !== 1'b0 || decMValid !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL midreset_relock: ready=%0b/%0b valid=%0b/%0b, required 0",
                 encSReady, decSReady, encMValid, decMValid);
      end
      applyStimulus();
    end
  endtask

  task automatic test_random();
    logic [127:0] k;
    for (int it = 0; it < 8; it++) begin
      startKey({$urandom, $urandom, $urandom, $urandom});
      for (int c = 0; c < 40; c++) begin
        sValid = ($urandom_range(0, 9) < 7);
        mReady = ($urandom_range(0, 9) < 7);
        sIn = {$urandom, $urandom, $urandom, $urandom};
        keyLoad = 1'b0;
        if ($urandom_range(0, 59) == 0) begin
          k = {$urandom, $urandom, $urandom, $urandom};
          expandKey(k);
          encKey = k;
          decKey = roundKeys[10];
          keyLoad = 1'b1;
        end
        #1;
        testsRun++;
        if (encSReady !== expReady() || decSReady !== expReady()) begin
          testsFailed++;
          $display("[TB] FAIL rand_ready it%0d c%0d: ready=%0b/%0b, required %0b", it, c, encSReady, decSReady, expReady());
        end
        testsRun++;
        if (encMValid !== eValid || decMValid !== eValid) begin
          testsFailed++;
          $display("[TB] FAIL rand_valid it%0d c%0d: valid=%0b/%0b, required %0b", it, c, encMValid, decMValid, eValid);
        end
        if (eValid) begin
          testsRun++;
          if (encSOut !== eEncS || encRound !== 4'(eEncRound) || encLast !== eLast ||
              decSOut !== eDecS || decRound !== 4'(eDecRound) || decLast !== eLast) begin
            testsFailed++;
            $display("[TB] FAIL rand_data it%0d c%0d: enc %h r%0d l%0b dec %h r%0d l%0b, required enc %h r%0d dec %h r%0d l%0b",
                     it, c, encSOut, encRound, encLast, decSOut, decRound, decLast,
                     eEncS, eEncRound, eDecS, eDecRound, eLast);
          end
        end
        applyStimulus();
      end
      keyLoad = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; keyLoad = 1'b0; sValid = 1'b0; mReady = 1'b0;
    encKey = '0; decKey = '0; sIn = '0;
    modelReset();
    buildSbox();
    @(negedge clk);
    test_reset();
    test_known_vectors();
    test_backpressure();
    test_abort();
    test_reset_midsequence();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
